// File: rtl/pe_writeback_pkg.sv
// Shared definitions for the PE write-back path: opcode codes, FSM states
// and the lane-mask helper that trims a beat to the active node length.
package pe_writeback_pkg;

  localparam int WB_P = 32;

  localparam logic [3:0] TYPE1FUN  = 4'd0;
  localparam logic [3:0] TYPE2FUN  = 4'd1;
  localparam logic [3:0] BOTTOMFUN = 4'd2;
  localparam logic [3:0] TYPE3FUN  = 4'd3;
  localparam logic [3:0] NOP_OP    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_STALL = 2'd2
  } wb_state_e;

  // TYPE1/TYPE2 beats carry half a node per half-beat, so they keep I_Nv/2
  // lanes; lanes at or beyond WB_P are never set, which clamps to WB_P.
  function automatic logic [WB_P-1:0] lane_mask(input logic [10:0] i_nv,
                                                input logic [3:0]  op);
    logic [10:0] keep;
    lane_mask = '0;
    keep = (op == TYPE1FUN || op == TYPE2FUN) ? {1'b0, i_nv[10:1]} : i_nv;
    for (int i = 0; i < WB_P; i++) begin
      lane_mask[i] = (11'(i) < keep);
    end
  endfunction

endpackage

// File: rtl/pe_writeback_fifo2.sv
// wb_fifo2: two-entry FIFO holding pending storage writes.
// Head is presented combinationally; push while full is honoured only with a pop.
module wb_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != 2'd0);
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/pe_writeback.sv
// PE write-back: masks each accepted beat, queues it, and issues alpha/beta writes.
// Optional WB_STALL_CNT_EN adds a saturating stall_cnt output.
module pe_writeback
  import pe_writeback_pkg::*;
#(
  parameter int P      = WB_P,
  parameter int Q      = 6,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pe_valid,
  input  logic [2*P*Q-1:0]    pe_o,
  input  logic [3:0]          opcode,
  input  logic [10:0]         I_Nv,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                mem_ready,
  output logic                in_ready,
  output logic                alpha_we,
  output logic                beta_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [2*P*Q-1:0]    mem_wdata,
  output logic [2*P*Q-1:0]    pe_o_before,
  output logic [3:0]          opcode_before,
  output logic [3:0]          opcode_delay,
  output logic                busy,
  output logic [1:0]          state_dbg
`ifdef WB_STALL_CNT_EN
  , output logic [15:0]       stall_cnt
`endif
);

  localparam int DW = 2 * P * Q;
  localparam int EW = ADDR_W + 2 + DW;

  wb_state_e      state_q, state_d;
  logic [DW-1:0]  pe_o_before_q, pe_o_before_d;
  logic [3:0]     opcode_before_q, opcode_before_d;
  logic [3:0]     opcode_delay_q, opcode_delay_d;

  logic [WB_P-1:0] mask;
  logic [DW-1:0]   masked;
  logic            is_alpha, is_beta, accept, push, pop, pending;
  logic [EW-1:0]   head;
  logic [1:0]      fifo_count;

  assign is_alpha = (opcode == TYPE1FUN) || (opcode == TYPE2FUN);
  assign is_beta  = (opcode == BOTTOMFUN) || (opcode == TYPE3FUN);
  assign pending  = (state_q != ST_IDLE);
  assign pop      = pending && mem_ready;
  assign in_ready = (fifo_count != 2'd2) || pop;
  assign accept   = pe_valid && in_ready;
  // Opcodes outside the four PE functions update history but never occupy the buffer.
  assign push     = accept && (is_alpha || is_beta);
  assign mask     = lane_mask(I_Nv, opcode);

  always_comb begin
    masked = pe_o;
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < P; i++) begin
        if (!mask[i]) masked[h*P*Q + i*Q +: Q] = '0;
      end
    end
  end

  wb_fifo2 #(.W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({is_alpha, is_beta, wr_addr, masked}),
    .dout  (head),
    .count (fifo_count)
  );

  // A pop in STALL completes the held write, so the exit target depends on occupancy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_WRITE;
      end
      ST_WRITE, ST_STALL: begin
        if (!mem_ready)                          state_d = ST_STALL;
        else if (fifo_count == 2'd1 && !push)    state_d = ST_IDLE;
        else                                     state_d = ST_WRITE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pe_o_before_d   = pe_o_before_q;
    opcode_before_d = opcode_before_q;
    opcode_delay_d  = opcode_delay_q;
    if (accept) begin
      pe_o_before_d   = pe_o;
      opcode_before_d = opcode;
      opcode_delay_d  = opcode_before_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pe_o_before_q   <= '0;
      opcode_before_q <= NOP_OP;
      opcode_delay_q  <= NOP_OP;
    end else begin
      state_q         <= state_d;
      pe_o_before_q   <= pe_o_before_d;
      opcode_before_q <= opcode_before_d;
      opcode_delay_q  <= opcode_delay_d;
    end
  end

  assign alpha_we      = pending && head[EW-1];
  assign beta_we       = pending && head[EW-2];
  assign mem_addr      = pending ? head[DW +: ADDR_W] : '0;
  assign mem_wdata     = pending ? head[DW-1:0] : '0;
  assign pe_o_before   = pe_o_before_q;
  assign opcode_before = opcode_before_q;
  assign opcode_delay  = opcode_delay_q;
  assign busy          = (fifo_count != 2'd0);
  assign state_dbg     = state_q;

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_STALL && !mem_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  // Upstream must respect in_ready; a beat offered while full would be lost.
  a_no_drop: assert property (@(posedge clk) disable iff (rst) !(pe_valid && !in_ready));

endmodule

// File: tb/tb_pe_writeback.sv
// Bench for pe_writeback: table-driven beats plus hand-written latency, stall
// and reset sequences; writes are scored against an expected queue.
module tb_pe_writeback;

  localparam int P  = 32;
  localparam int Q  = 6;
  localparam int AW = 8;
  localparam int DW = 2 * P * Q;
  localparam int W  = 2 + AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pe_valid = 1'b0;
  logic [DW-1:0] pe_o = '0;
  logic [3:0]    opcode = 4'd0;
  logic [10:0]   I_Nv = 11'd2;
  logic [AW-1:0] wr_addr = '0;
  logic          mem_ready = 1'b1;
  logic          in_ready, alpha_we, beta_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, pe_o_before;
  logic [3:0]    opcode_before, opcode_delay;
  logic [1:0]    state_dbg;
`ifdef WB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  pe_writeback #(.P(P), .Q(Q), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .pe_valid      (pe_valid),
    .pe_o          (pe_o),
    .opcode        (opcode),
    .I_Nv          (I_Nv),
    .wr_addr       (wr_addr),
    .mem_ready     (mem_ready),
    .in_ready      (in_ready),
    .alpha_we      (alpha_we),
    .beta_we       (beta_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .pe_o_before   (pe_o_before),
    .opcode_before (opcode_before),
    .opcode_delay  (opcode_delay),
    .busy          (busy),
    .state_dbg     (state_dbg)
`ifdef WB_STALL_CNT_EN
    , .stall_cnt   (stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] hist_pe = '0;
  logic [3:0]    hist_op = 4'hF;
  logic [3:0]    hist_dly = 4'hF;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [DW-1:0] apply_keep(input logic [DW-1:0] d, input int keep);
    logic [DW-1:0] r;
    r = d;
    for (int h = 0; h < 2; h++) begin
      for (int i = keep; i < P; i++) r[h*P*Q + i*Q +: Q] = '0;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // driver: offer one beat for one clock, then check the published history
  task automatic drive_beat(input logic [3:0] op, input logic [10:0] nv,
                            input logic [AW-1:0] addr, input logic [DW-1:0] d,
                            input int keep, input logic ea, input logic eb);
    check("in_ready_before_beat", W'(in_ready), W'(1'b1));
    pe_valid = 1'b1;
    opcode   = op;
    I_Nv     = nv;
    wr_addr  = addr;
    pe_o     = d;
    if (ea || eb) exp_q.push_back({ea, eb, addr, apply_keep(d, keep)});
    hist_dly = hist_op;
    hist_op  = op;
    hist_pe  = d;
    step();
    pe_valid = 1'b0;
    check("pe_o_before", W'(pe_o_before), W'(hist_pe));
    check("opcode_before", W'(opcode_before), W'(hist_op));
    check("opcode_delay", W'(opcode_delay), W'(hist_dly));
  endtask

  // scoreboard: each completed write must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && (alpha_we || beta_we) && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual_addr=%h we=%b%b required=none",
                 mem_addr, alpha_we, beta_we);
      end else begin
        check("write", {alpha_we, beta_we, mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [10:0] nv;
    logic [7:0]  addr;
    int          keep;
    logic        ea;
    logic        eb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [DW-1:0] da, db, dc;
    logic [AW-1:0] held_addr;

    vecs[0] = '{4'd0, 11'd16,   8'h10, 8,  1'b1, 1'b0};
    vecs[1] = '{4'd1, 11'd1024, 8'h21, 32, 1'b1, 1'b0};
    vecs[2] = '{4'd2, 11'd2,    8'h32, 2,  1'b0, 1'b1};
    vecs[3] = '{4'd3, 11'd64,   8'h43, 32, 1'b0, 1'b1};
    vecs[4] = '{4'd3, 11'd16,   8'h54, 16, 1'b0, 1'b1};
    vecs[5] = '{4'd0, 11'd2,    8'h65, 1,  1'b1, 1'b0};
    vecs[6] = '{4'd1, 11'd128,  8'h76, 32, 1'b1, 1'b0};
    vecs[7] = '{4'd7, 11'd32,   8'h87, 0,  1'b0, 1'b0};
    vecs[8] = '{4'd2, 11'd1024, 8'h98, 32, 1'b0, 1'b1};
    vecs[9] = '{4'd1, 11'd32,   8'hA9, 16, 1'b1, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_alpha_we", W'(alpha_we), '0);
    check("rst_beta_we", W'(beta_we), '0);
    check("rst_mem_addr", W'(mem_addr), '0);
    check("rst_mem_wdata", W'(mem_wdata), '0);
    check("rst_pe_o_before", W'(pe_o_before), '0);
    check("rst_opcode_before", W'(opcode_before), W'(4'hF));
    check("rst_opcode_delay", W'(opcode_delay), W'(4'hF));
    check("rst_busy", W'(busy), '0);
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    check("rst_state", W'(state_dbg), '0);
    rst = 1'b0;
    step();

    // TYPE1, I_Nv=16: single alpha pulse the clock after accept
    check("t1_no_we_before", W'({alpha_we, beta_we}), '0);
    drive_beat(4'd0, 11'd16, 8'h05, rand_data(), 8, 1'b1, 1'b0);
    check("t1_alpha_we_n1", W'({alpha_we, beta_we}), W'(2'b10));
    check("t1_busy_n1", W'(busy), W'(1'b1));
    step();
    check("t1_alpha_we_drop", W'({alpha_we, beta_we}), '0);
    check("t1_busy_drop", W'(busy), '0);

    // table of isolated beats
    for (int v = 0; v < 10; v++) begin
      drive_beat(vecs[v].op, vecs[v].nv, vecs[v].addr, rand_data(),
                 vecs[v].keep, vecs[v].ea, vecs[v].eb);
      check("vec_route", W'({alpha_we, beta_we}), W'({vecs[v].ea, vecs[v].eb}));
      step();
    end

    // TYPE3 then TYPE2 back-to-back
    drive_beat(4'd3, 11'd32, 8'hC0, rand_data(), 32, 1'b0, 1'b1);
    check("b2b_first_beta", W'({alpha_we, beta_we}), W'(2'b01));
    drive_beat(4'd1, 11'd32, 8'hC1, rand_data(), 16, 1'b1, 1'b0);
    check("b2b_second_alpha", W'({alpha_we, beta_we}), W'(2'b10));
    check("b2b_opcode_before", W'(opcode_before), W'(4'd1));
    check("b2b_opcode_delay", W'(opcode_delay), W'(4'd3));
    step();
    step();

    // stall with two beats queued
    mem_ready = 1'b0;
    da = rand_data();
    db = rand_data();
    drive_beat(4'd2, 11'd8, 8'hD0, da, 8, 1'b0, 1'b1);
    drive_beat(4'd0, 11'd64, 8'hD1, db, 32, 1'b1, 1'b0);
    held_addr = mem_addr;
    check("stall_head_addr", W'(held_addr), W'(8'hD0));
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_in_ready", W'(in_ready), '0);
      check("stall_mem_addr", W'(mem_addr), W'(held_addr));
      check("stall_mem_wdata", W'(mem_wdata), W'(apply_keep(da, 8)));
      check("stall_we", W'({alpha_we, beta_we}), W'(2'b01));
    end
`ifdef WB_STALL_CNT_EN
    check("stall_cnt", W'(stall_cnt), W'(16'd3));
`endif
    mem_ready = 1'b1;
    repeat (4) step();
    check("stall_drained", W'(busy), '0);

    // reset with two beats queued
    mem_ready = 1'b0;
    dc = rand_data();
    drive_beat(4'd1, 11'd16, 8'hE0, dc, 8, 1'b1, 1'b0);
    drive_beat(4'd3, 11'd4, 8'hE1, rand_data(), 4, 1'b0, 1'b1);
    check("mid_busy", W'(busy), W'(1'b1));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_we", W'({alpha_we, beta_we}), '0);
    check("mid_rst_busy", W'(busy), '0);
    check("mid_rst_opcode_before", W'(opcode_before), W'(4'hF));
    check("mid_rst_opcode_delay", W'(opcode_delay), W'(4'hF));
    check("mid_rst_in_ready", W'(in_ready), W'(1'b1));
    exp_q.delete();
    hist_op  = 4'hF;
    hist_dly = 4'hF;
    hist_pe  = '0;
    step();
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("post_rst_no_we", W'({alpha_we, beta_we}), '0);
    end

    check("exp_q_empty", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
